rr_sel_arbiter: RTL

- Round-robin arbiter sitting directly upstream of the K-to-1 word mux.
- Chooses one of K requesting sources and drives the mux select with a registered `sel`.
- Holds `sel` stable until the downstream consumer accepts the selected word through a valid/ready handshake.
- Gives every source fair, starvation-free access to the shared SIZE-bit output path.

---
 rtl/rr_sel_arbiter_if.sv | 34 +++
 rtl/rr_sel_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bundle between the K requesting sources, the round-robin
// arbiter and the downstream consumer of the K-to-1 word mux.
interface rr_sel_arbiter_if #(
    parameter int K = 4
);
    localparam int SW = $clog2(K);

    logic [K-1:0]  req;
    logic          out_ready;
    logic [SW-1:0] sel;
    logic [K-1:0]  grant;
    logic          out_valid;
    logic [SW-1:0] ptr_dbg;

    // Sources and consumer side: drives requests and ready, observes the select.
    modport master (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  ptr_dbg
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output ptr_dbg
    );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select of a K-to-1 word mux.
// The chosen select is held until the consumer takes the word
// (out_valid & out_ready); on that edge arbitration re-runs immediately from
// the advanced pointer, so a continuously ready consumer sees one word per cycle.
// Every output comes straight from a register.
module rr_sel_arbiter #(
    parameter int K = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_sel_arbiter_if.slave bus
);
    localparam int SW = $clog2(K);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] sel_nxt;
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] ptr_adv;
    logic [K-1:0]  grant_q;
    logic [K-1:0]  grant_nxt;

    // First requester at or above base, wrapping modulo K; returns base when
    // nothing is requesting (callers only use the result when req != 0).
    function automatic logic [SW-1:0] rr_pick(input logic [K-1:0] r,
                                              input logic [SW-1:0] base);
        logic [SW-1:0] pick;
        logic          found;
        int            idx;
        pick  = base;
        found = 1'b0;
        for (int off = 0; off < K; off++) begin
            idx = int'(base) + off;
            if (idx >= K) begin
                idx = idx - K;
            end
            if (!found && r[idx]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [K-1:0] one_hot(input logic [SW-1:0] i);
        logic [K-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Source just served drops to lowest priority; wrap explicitly so that
    // non-power-of-two K never produces an index >= K.
    assign ptr_adv = (sel_q == SW'(K - 1)) ? '0 : sel_q + SW'(1);

    // Next-state and next-output decode: arbitrate from IDLE, or re-arbitrate
    // on the handshake edge using the advanced pointer.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        grant_nxt = grant_q;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_nxt   = rr_pick(bus.req, ptr_q);
                    grant_nxt = one_hot(sel_nxt);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    ptr_nxt = ptr_adv;
                    if (|bus.req) begin
                        sel_nxt   = rr_pick(bus.req, ptr_adv);
                        grant_nxt = one_hot(sel_nxt);
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, select, grant and pointer registers; reset drops any pending transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            ptr_q   <= ptr_nxt;
            grant_q <= grant_nxt;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = (state == BUSY);
    assign bus.ptr_dbg   = ptr_q;
endmodule
